// File: rtl/fma_round_pack_pkg.sv
// rtl/fma_round_pack_pkg.sv - shared widths, rounding encodings and binary32 constants for the FMA round/pack stage
package fma_round_pack_pkg;

    localparam int SIG_WIDTH = 23;
    localparam int EXP_WIDTH = 8;
    localparam int BIAS      = 127;

    // Derived widths: normalized significand carries hidden + fraction + G/R/S,
    // incoming exponent has two extra bits for signed overflow/underflow headroom.
    localparam int SIG_IN_W  = SIG_WIDTH + 4;
    localparam int EXP_IN_W  = EXP_WIDTH + 2;
    localparam int RES_W     = SIG_WIDTH + EXP_WIDTH + 1;
    localparam int SUM_W     = SIG_WIDTH + 2;

    // Largest finite biased exponent is 2*BIAS; anything at or above the next
    // value lands in the all-ones exponent field.
    localparam int EXP_MAX_FINITE = 2 * BIAS;
    localparam int EXP_OVF        = EXP_MAX_FINITE + 1;

    typedef enum logic [1:0] {
        RND_RNE = 2'b00,
        RND_RTZ = 2'b01,
        RND_RUP = 2'b10,
        RND_RDN = 2'b11
    } rnd_mode_e;

    // Magnitudes only (sign is prepended by the user).
    localparam logic [RES_W-2:0] POS_INF        = {{EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
    localparam logic [RES_W-2:0] MAX_FINITE_MAG = {{(EXP_WIDTH-1){1'b1}}, 1'b0, {SIG_WIDTH{1'b1}}};

    // Bit positions inside out_flags = {overflow, underflow, inexact}.
    localparam int FLAG_OV = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Saturated result on overflow: infinity when the mode rounds away from
    // zero for this sign, otherwise the largest finite magnitude.
    function automatic logic [RES_W-1:0] overflow_value(input logic sign, input logic [1:0] mode);
        logic to_inf;
        case (mode)
            RND_RNE: to_inf = 1'b1;
            RND_RTZ: to_inf = 1'b0;
            RND_RUP: to_inf = ~sign;
            default: to_inf = sign;
        endcase
        return {sign, (to_inf ? POS_INF : MAX_FINITE_MAG)};
    endfunction

endpackage

// File: rtl/fma_round_pack_decide.sv
// rtl/fma_round_pack_decide.sv - combinational rounding decision (fma_round_decide) from L/G/T, sign and mode
module fma_round_decide
    import fma_round_pack_pkg::*;
(
    input  logic       lsb,
    input  logic       guard,
    input  logic       tail,
    input  logic       sign,
    input  logic [1:0] rnd_mode,
    output logic       inc,
    output logic       inexact
);

    // Increment decision per rounding mode; any discarded bit makes the result inexact.
    always_comb begin
        inexact = guard | tail;
        case (rnd_mode)
            RND_RNE: inc = guard & (tail | lsb);
            RND_RTZ: inc = 1'b0;
            RND_RUP: inc = ~sign & (guard | tail);
            RND_RDN: inc = sign & (guard | tail);
            default: inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/fma_round_pack.sv
// rtl/fma_round_pack.sv - two-stage round and pack of the binary32 FMA result; FPFMA_EXC_FLAGS_EN enables out_flags
module fma_round_pack
    import fma_round_pack_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIG_IN_W-1:0] in_sig,
    input  logic [EXP_IN_W-1:0] in_exp,
    input  logic                in_sign,
    input  logic                in_special,
    input  logic [RES_W-1:0]    in_special_val,
    input  logic [1:0]          rnd_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RES_W-1:0]    out_result,
    output logic [2:0]          out_flags
);

    localparam logic signed [EXP_IN_W:0] EXP_OVF_S = (EXP_IN_W+1)'(EXP_OVF);

    // Stage 1 registers
    logic                v1_q, v1_d;
    logic [SUM_W-1:0]    sum1_q, sum1_d;
    logic                hidden1_q, hidden1_d;
    logic                sign1_q, sign1_d;
    logic [EXP_IN_W-1:0] exp1_q, exp1_d;
    logic                special1_q, special1_d;
    logic [RES_W-1:0]    sval1_q, sval1_d;
    logic [1:0]          rnd1_q, rnd1_d;

    // Stage 2 registers
    logic                v2_q, v2_d;
    logic [RES_W-1:0]    result_q, result_d;

    logic s2_accept;
    logic s1_load;
    logic inc;
    logic inexact_raw;

    fma_round_decide u_decide (
        .lsb      (in_sig[3]),
        .guard    (in_sig[2]),
        .tail     (in_sig[1] | in_sig[0]),
        .sign     (in_sign),
        .rnd_mode (rnd_mode),
        .inc      (inc),
        .inexact  (inexact_raw)
    );

    // Handshake: stage 2 drains when downstream takes it or it is empty;
    // stage 1 advances when empty or stage 2 is taking its contents.
    always_comb begin
        s2_accept = out_ready | ~v2_q;
        s1_load   = ~v1_q | s2_accept;
        in_ready  = s1_load;
    end

    // Stage 1: apply the rounding increment and capture the context for packing.
    always_comb begin
        v1_d       = v1_q;
        sum1_d     = sum1_q;
        hidden1_d  = hidden1_q;
        sign1_d    = sign1_q;
        exp1_d     = exp1_q;
        special1_d = special1_q;
        sval1_d    = sval1_q;
        rnd1_d     = rnd1_q;
        if (s1_load) begin
            v1_d = in_valid;
            if (in_valid) begin
                sum1_d     = {1'b0, in_sig[SIG_IN_W-1:3]} + SUM_W'(inc);
                hidden1_d  = in_sig[SIG_IN_W-1];
                sign1_d    = in_sign;
                exp1_d     = in_exp;
                special1_d = in_special;
                sval1_d    = in_special_val;
                rnd1_d     = rnd_mode;
            end
        end
    end

    // Stage 2 datapath: absorb significand carry-out, then classify the result.
    logic signed [EXP_IN_W:0] exp_r;
    logic [SIG_WIDTH-1:0]     frac;
    logic                     is_zero_in;
    logic                     is_ovf;
    logic                     is_unf;
    logic [RES_W-1:0]         packed_val;

    always_comb begin
        exp_r = $signed({exp1_q[EXP_IN_W-1], exp1_q})
              + $signed({{EXP_IN_W{1'b0}}, sum1_q[SUM_W-1]});
        frac  = sum1_q[SUM_W-1] ? '0 : sum1_q[SIG_WIDTH-1:0];
        is_zero_in = ~special1_q & ~hidden1_q;
        is_ovf     = ~exp_r[EXP_IN_W] && (exp_r >= EXP_OVF_S);
        is_unf     = exp_r[EXP_IN_W] || (exp_r == '0);
        if (special1_q) begin
            packed_val = sval1_q;
        end else if (is_zero_in) begin
            packed_val = {sign1_q, {(RES_W-1){1'b0}}};
        end else if (is_ovf) begin
            packed_val = overflow_value(sign1_q, rnd1_q);
        end else if (is_unf) begin
            packed_val = {sign1_q, {(RES_W-1){1'b0}}};
        end else begin
            packed_val = {sign1_q, exp_r[EXP_WIDTH-1:0], frac};
        end
    end

    // Stage 2: load the packed word when stage 1 hands over a valid result.
    always_comb begin
        v2_d     = v2_q;
        result_d = result_q;
        if (s2_accept) begin
            v2_d = v1_q;
            if (v1_q) begin
                result_d = packed_val;
            end
        end
    end

`ifdef FPFMA_EXC_FLAGS_EN
    logic nx1_q, nx1_d;
    logic [2:0] flags_q, flags_d;

    // Exception flags follow the same classification priority as the packed value.
    always_comb begin
        nx1_d   = nx1_q;
        flags_d = flags_q;
        if (s1_load && in_valid) begin
            nx1_d = inexact_raw;
        end
        if (s2_accept && v1_q) begin
            flags_d = '0;
            if (special1_q || is_zero_in) begin
                flags_d = '0;
            end else if (is_ovf) begin
                flags_d[FLAG_OV] = 1'b1;
                flags_d[FLAG_NX] = 1'b1;
            end else if (is_unf) begin
                flags_d[FLAG_UF] = 1'b1;
                flags_d[FLAG_NX] = 1'b1;
            end else begin
                flags_d[FLAG_NX] = nx1_q;
            end
        end
    end

    // Flag registers share stage timing with the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nx1_q   <= 1'b0;
            flags_q <= '0;
        end else begin
            nx1_q   <= nx1_d;
            flags_q <= flags_d;
        end
    end

    assign out_flags = flags_q;

    logic unused_sum_msb;
    assign unused_sum_msb = sum1_q[SIG_WIDTH];
`else
    assign out_flags = 3'b000;

    logic unused_bits;
    assign unused_bits = ^{inexact_raw, sum1_q[SIG_WIDTH]};
`endif

    // Pipeline state registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q       <= 1'b0;
            sum1_q     <= '0;
            hidden1_q  <= 1'b0;
            sign1_q    <= 1'b0;
            exp1_q     <= '0;
            special1_q <= 1'b0;
            sval1_q    <= '0;
            rnd1_q     <= 2'b00;
            v2_q       <= 1'b0;
            result_q   <= '0;
        end else begin
            v1_q       <= v1_d;
            sum1_q     <= sum1_d;
            hidden1_q  <= hidden1_d;
            sign1_q    <= sign1_d;
            exp1_q     <= exp1_d;
            special1_q <= special1_d;
            sval1_q    <= sval1_d;
            rnd1_q     <= rnd1_d;
            v2_q       <= v2_d;
            result_q   <= result_d;
        end
    end

    assign out_valid  = v2_q;
    assign out_result = result_q;

endmodule

// File: tb/tb_fma_round_pack.sv
// tb/tb_fma_round_pack.sv - self-checking bench for fma_round_pack with a behavioural rounding model
module tb_fma_round_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [26:0] in_sig;
    logic [9:0]  in_exp;
    logic        in_sign;
    logic        in_special;
    logic [31:0] in_special_val;
    logic [1:0]  rnd_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    int total = 0;
    int bad   = 0;

    logic [34:0] sb_q[$];

`ifdef FPFMA_EXC_FLAGS_EN
    localparam logic [2:0] FLAG_MASK = 3'b111;
`else
    localparam logic [2:0] FLAG_MASK = 3'b000;
`endif

    always #5 clk = ~clk;

    fma_round_pack dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sig         (in_sig),
        .in_exp         (in_exp),
        .in_sign        (in_sign),
        .in_special     (in_special),
        .in_special_val (in_special_val),
        .rnd_mode       (rnd_mode),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_flags      (out_flags)
    );

    // Reference: integer significand, round by mode, renormalise, then saturate/flush.
    function automatic logic [34:0] model(input logic [26:0] sig, input logic [9:0] ex,
                                          input logic sg, input logic sp,
                                          input logic [31:0] sv, input logic [1:0] md);
        int mant;
        int e;
        bit g, t, l, up, to_inf;
        logic [31:0] r;
        logic [2:0] f;
        if (sp) return {sv, 3'b000};
        if (!sig[26]) return {sg, 31'b0, 3'b000};
        mant = int'(sig[26:3]);
        g = sig[2];
        t = sig[1] | sig[0];
        l = sig[3];
        case (md)
            2'd0:    up = g && (t || l);
            2'd1:    up = 1'b0;
            2'd2:    up = !sg && (g || t);
            default: up = sg && (g || t);
        endcase
        mant = mant + int'(up);
        e = int'($signed(ex));
        if (mant >= 32'h0100_0000) begin
            mant = mant / 2;
            e = e + 1;
        end
        if (e >= 255) begin
            to_inf = (md == 2'd0) || (md == 2'd2 && !sg) || (md == 2'd3 && sg);
            r = {sg, (to_inf ? 31'h7F80_0000 : 31'h7F7F_FFFF)};
            f = 3'b101;
        end else if (e <= 0) begin
            r = {sg, 31'b0};
            f = 3'b011;
        end else begin
            r = {sg, 8'(e), 23'(mant)};
            f = {2'b00, g | t};
        end
        return {r, f & FLAG_MASK};
    endfunction

    task automatic rand_input();
        int cls;
        int ev;
        in_sig     = 27'($urandom);
        in_sig[26] = ($urandom_range(0, 15) != 0);
        cls = int'($urandom_range(0, 3));
        case (cls)
            0:       ev = int'($urandom_range(1, 254));
            1:       ev = int'($urandom_range(250, 260));
            2:       ev = int'($urandom_range(0, 6)) - 3;
            default: ev = int'($urandom_range(0, 1023)) - 512;
        endcase
        in_exp         = ev[9:0];
        in_sign        = 1'($urandom);
        in_special     = ($urandom_range(0, 15) == 0);
        in_special_val = $urandom;
        rnd_mode       = 2'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_sig = '0; in_exp = '0; in_sign = 1'b0;
        in_special = 1'b0; in_special_val = '0; rnd_mode = 2'b00;
        repeat (3) @(negedge clk);
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        if (out_result !== 32'h0) begin bad++; $display("FAIL reset_out_result got=%h want=00000000", out_result); end
        if (out_flags !== 3'b000) begin bad++; $display("FAIL reset_out_flags got=%b want=000", out_flags); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
        end
    endtask

    localparam int NDIR = 14;
    logic [26:0] d_sig [NDIR] = '{27'h4000000, 27'h7FFFFFC, 27'h400000C, 27'h400000C, 27'h400000C,
                                 27'h4000000, 27'h4000000, 27'h4000000, 27'h4000000, 27'h4000000,
                                 27'h0000005, 27'h7FFFFFC, 27'h4000004, 27'h4000004};
    logic [9:0]  d_exp [NDIR] = '{10'd127, 10'd127, 10'd127, 10'd127, 10'd127,
                                 10'd255, 10'd255, 10'd0, 10'd127, 10'd255,
                                 10'd127, 10'd254, 10'd127, 10'd127};
    logic        d_sgn [NDIR] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    logic        d_spc [NDIR] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    logic [1:0]  d_md  [NDIR] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2,
                                 2'd0, 2'd0, 2'd0, 2'd2};
    logic [31:0] d_res [NDIR] = '{32'h3F800000, 32'h40000000, 32'h3F800002, 32'h3F800001, 32'hBF800002,
                                 32'h7F800000, 32'h7F7FFFFF, 32'h00000000, 32'h7FC00000, 32'hFF7FFFFF,
                                 32'h80000000, 32'h7F800000, 32'h3F800000, 32'h3F800001};
    logic [2:0]  d_flg [NDIR] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001,
                                 3'b101, 3'b101, 3'b011, 3'b000, 3'b101,
                                 3'b000, 3'b101, 3'b001, 3'b001};

    task automatic test_directed();
        for (int i = 0; i < NDIR; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            out_ready = 1'b1;
            in_sig = d_sig[i];
            in_exp = d_exp[i];
            in_sign = d_sgn[i];
            in_special = d_spc[i];
            in_special_val = 32'h7FC00000;
            rnd_mode = d_md[i];
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            total += 3;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_valid got=%0b want=1", i, out_valid); end
            if (out_result !== d_res[i]) begin bad++; $display("FAIL dir%0d_result got=%h want=%h", i, out_result, d_res[i]); end
            if (out_flags !== (d_flg[i] & FLAG_MASK)) begin
                bad++; $display("FAIL dir%0d_flags got=%b want=%b", i, out_flags, d_flg[i] & FLAG_MASK);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [34:0] e;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            rand_input();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++; $display("FAIL rand_unexpected got=%h", out_result);
                end else begin
                    e = sb_q.pop_front();
                    if ({out_result, out_flags} !== e) begin
                        bad++; $display("FAIL rand_result got=%h/%b want=%h/%b", out_result, out_flags, e[34:3], e[2:0]);
                    end
                end
            end
            if (in_valid && in_ready)
                sb_q.push_back(model(in_sig, in_exp, in_sign, in_special, in_special_val, rnd_mode));
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++; $display("FAIL drain_unexpected got=%h", out_result);
                end else begin
                    e = sb_q.pop_front();
                    if ({out_result, out_flags} !== e) begin
                        bad++; $display("FAIL drain_result got=%h/%b want=%h/%b", out_result, out_flags, e[34:3], e[2:0]);
                    end
                end
            end
        end
        total++;
        if (sb_q.size() != 0) begin bad++; $display("FAIL rand_missing got=%0d left want=0", sb_q.size()); end
        sb_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [26:0] s [4];
        logic [9:0]  x [4];
        logic [34:0] e;
        logic [31:0] held;
        bit          prev_stall;
        int          idx;
        int          got;
        for (int i = 0; i < 4; i++) begin
            s[i] = 27'($urandom) | 27'h4000000;
            x[i] = 10'($urandom_range(1, 200));
        end
        idx = 0;
        got = 0;
        prev_stall = 1'b0;
        held = '0;
        in_special = 1'b0;
        in_sign = 1'b0;
        rnd_mode = 2'd0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 3);
            in_valid = (idx < 4);
            if (idx < 4) begin
                in_sig = s[idx];
                in_exp = x[idx];
            end
            #1;
            if (cyc == 2) begin
                total += 2;
                if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_in_ready got=%0b want=0", in_ready); end
                if (idx != 2) begin bad++; $display("FAIL b2b_accepts got=%0d want=2", idx); end
            end
            if (prev_stall) begin
                total++;
                if (out_result !== held) begin bad++; $display("FAIL b2b_hold got=%h want=%h", out_result, held); end
            end
            prev_stall = out_valid && !out_ready;
            held = out_result;
            if (out_valid && out_ready) begin
                total++;
                got++;
                e = (sb_q.size() != 0) ? sb_q.pop_front() : 35'h0;
                if ({out_result, out_flags} !== e) begin
                    bad++; $display("FAIL b2b_order got=%h/%b want=%h/%b", out_result, out_flags, e[34:3], e[2:0]);
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(in_sig, in_exp, in_sign, in_special, in_special_val, rnd_mode));
                idx++;
            end
        end
        total++;
        if (got != 4) begin bad++; $display("FAIL b2b_delivered got=%0d want=4", got); end
        sb_q.delete();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            rand_input();
            in_sig[26] = 1'b1;
            in_special = 1'b0;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_busy got=%0b want=1", out_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        total += 3;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%0b want=0", out_valid); end
        if (out_result !== 32'h0) begin bad++; $display("FAIL mid_reset_result got=%h want=00000000", out_result); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready got=%0b want=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_flushed cyc%0d got=%0b want=0", cyc, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
